// File: rtl/seq_div_pkg.sv
// Shared sizing and state encoding for the sequential restoring divider.
package seq_div_pkg;
    localparam int DIV_WIDTH_DEFAULT = 32;
    localparam int DIV_CNT_W_DEFAULT = $clog2(DIV_WIDTH_DEFAULT) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/sub_borrow.sv
// Combinational N-bit subtractor built as a ripple full-adder chain: a + ~b + 1.
// borrow is the MSB of the difference; callers zero-extend so it flags a < b.
module sub_borrow #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);
    always_comb begin
        logic c;
        c    = 1'b1;
        diff = '0;
        for (int i = 0; i < N; i++) begin
            diff[i] = a[i] ^ ~b[i] ^ c;
            c       = (a[i] & ~b[i]) | (c & (a[i] ^ ~b[i]));
        end
    end

    assign borrow = diff[N-1];
endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, start/busy/done handshake.
// Results appear WIDTH edges after the accept edge; divide-by-zero completes on the next edge.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] m_reg;
    logic             dbz_reg;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             unused_diff_msb;

    // The partial remainder stays below the divisor, so WIDTH bits hold it;
    // the extra subtractor bit only serves as the borrow.
    assign trial = {r_reg, q_reg[WIDTH-1]};

    sub_borrow #(.N(WIDTH + 1)) u_sub (
        .a      (trial),
        .b      ({1'b0, m_reg}),
        .diff   (diff),
        .borrow (borrow)
    );

    assign unused_diff_msb = diff[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            q_reg   <= '0;
            r_reg   <= '0;
            m_reg   <= '0;
            dbz_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= divisor;
                        count <= '0;
                        if (divisor == '0) begin
                            q_reg   <= '1;
                            r_reg   <= dividend;
                            dbz_reg <= 1'b1;
                            state   <= DONE;
                        end else begin
                            q_reg   <= dividend;
                            r_reg   <= '0;
                            dbz_reg <= 1'b0;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!borrow) begin
                        r_reg <= diff[WIDTH-1:0];
                        q_reg <= {q_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        r_reg <= trial[WIDTH-1:0];
                        q_reg <= {q_reg[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy        = (state == RUN);
    assign done        = (state == DONE);
    assign quotient    = q_reg;
    assign remainder   = r_reg;
    assign div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed bench for seq_divider against a plain / and % reference model.
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int vectors     = 0;
    int miscompares = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Launches one operation from IDLE and returns what was observed; lat counts
    // cycles after the accept edge (first cycle after it is 1).
    task automatic drive_op(input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] q, output logic [31:0] r, output logic z,
                            output int lat, output int busy_n, output int done_w);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat      = 1;
        busy_n   = 0;
        forever begin
            if (busy) busy_n++;
            if (done || lat >= 100) break;
            @(posedge clk); #1;
            lat++;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
        @(posedge clk); #1;
        done_w = done ? 2 : 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
        vectors++; if (quotient !== 32'd0) begin miscompares++; $display("FAIL reset_q got=%0h exp=0", quotient); end
        vectors++; if (remainder !== 32'd0) begin miscompares++; $display("FAIL reset_r got=%0h exp=0", remainder); end
        vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_start_dropped got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        logic [31:0] q, r; logic z; int lat, bn, dw;
        drive_op(32'd100, 32'd7, q, r, z, lat, bn, dw);
        vectors++; if (q !== 32'd14) begin miscompares++; $display("FAIL basic_q got=%0d exp=14", q); end
        vectors++; if (r !== 32'd2) begin miscompares++; $display("FAIL basic_r got=%0d exp=2", r); end
        vectors++; if (z !== 1'b0) begin miscompares++; $display("FAIL basic_dbz got=%b exp=0", z); end
        vectors++; if (lat != 33) begin miscompares++; $display("FAIL basic_latency got=%0d exp=33", lat); end
        vectors++; if (bn != 32) begin miscompares++; $display("FAIL basic_busy_cycles got=%0d exp=32", bn); end
        vectors++; if (dw != 1) begin miscompares++; $display("FAIL basic_done_width got=%0d exp=1", dw); end
    endtask

    task automatic test_corners();
        logic [31:0] tbl [4][4];
        logic [31:0] q, r; logic z; int lat, bn, dw;
        tbl[0] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0};
        tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0};
        tbl[2] = '{32'd5, 32'd9, 32'd0, 32'd5};
        tbl[3] = '{32'd0, 32'd3, 32'd0, 32'd0};
        for (int i = 0; i < 4; i++) begin
            drive_op(tbl[i][0], tbl[i][1], q, r, z, lat, bn, dw);
            vectors++; if (q !== tbl[i][2]) begin miscompares++; $display("FAIL corner%0d_q got=%0h exp=%0h", i, q, tbl[i][2]); end
            vectors++; if (r !== tbl[i][3]) begin miscompares++; $display("FAIL corner%0d_r got=%0h exp=%0h", i, r, tbl[i][3]); end
            vectors++; if (lat != 33) begin miscompares++; $display("FAIL corner%0d_latency got=%0d exp=33", i, lat); end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] q, r; logic z; int lat, bn, dw;
        drive_op(32'd1234, 32'd0, q, r, z, lat, bn, dw);
        vectors++; if (q !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL dz_q got=%0h exp=ffffffff", q); end
        vectors++; if (r !== 32'd1234) begin miscompares++; $display("FAIL dz_r got=%0d exp=1234", r); end
        vectors++; if (z !== 1'b1) begin miscompares++; $display("FAIL dz_flag got=%b exp=1", z); end
        vectors++; if (lat != 1) begin miscompares++; $display("FAIL dz_latency got=%0d exp=1", lat); end
        vectors++; if (bn != 0) begin miscompares++; $display("FAIL dz_busy_cycles got=%0d exp=0", bn); end
        vectors++; if (dw != 1) begin miscompares++; $display("FAIL dz_done_width got=%0d exp=1", dw); end
    endtask

    task automatic test_start_ignored();
        logic [31:0] q, r; logic z; int lat, bn, dw, n;
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        dividend = 32'd9; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dividend = 32'd0; divisor = 32'd0;
        n = 11;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++; if (n != 33) begin miscompares++; $display("FAIL ign_latency got=%0d exp=33", n); end
        vectors++; if (quotient !== 32'd14) begin miscompares++; $display("FAIL ign_q got=%0d exp=14", quotient); end
        vectors++; if (remainder !== 32'd2) begin miscompares++; $display("FAIL ign_r got=%0d exp=2", remainder); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL ign_done_width got=%b exp=0", done); end
        drive_op(32'd9, 32'd3, q, r, z, lat, bn, dw);
        vectors++; if (q !== 32'd3) begin miscompares++; $display("FAIL b2b_q got=%0d exp=3", q); end
        vectors++; if (r !== 32'd0) begin miscompares++; $display("FAIL b2b_r got=%0d exp=0", r); end
        vectors++; if (lat != 33) begin miscompares++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
    endtask

    task automatic test_rst_mid_run();
        logic [31:0] q, r; logic z; int lat, bn, dw; bit seen;
        dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got=%b exp=0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done got=%b exp=0", done); end
        vectors++; if (quotient !== 32'd0) begin miscompares++; $display("FAIL abort_q got=%0h exp=0", quotient); end
        vectors++; if (remainder !== 32'd0) begin miscompares++; $display("FAIL abort_r got=%0h exp=0", remainder); end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL abort_no_done got=%b exp=0", seen); end
        drive_op(32'd1000, 32'd3, q, r, z, lat, bn, dw);
        vectors++; if (q !== 32'd333) begin miscompares++; $display("FAIL abort_redo_q got=%0d exp=333", q); end
        vectors++; if (r !== 32'd1) begin miscompares++; $display("FAIL abort_redo_r got=%0d exp=1", r); end
    endtask

    task automatic test_rst_with_start();
        rst = 1'b1; start = 1'b1; dividend = 32'd50; divisor = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_start_done got=%b exp=0", done); end
        vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL rst_start_dbz got=%b exp=0", div_by_zero); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_start_idle got=%b%b exp=00", busy, done); end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r, eq, er; logic z, ez; int lat, bn, dw, mode;
        for (int i = 0; i < 60; i++) begin
            a    = $urandom;
            mode = $urandom_range(0, 4);
            case (mode)
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = a | 32'h8000_0000;
                3:       begin a = 32'($urandom_range(0, 5000)); b = 32'($urandom_range(1, 300)); end
                default: b = $urandom;
            endcase
            if (b == 32'd0) begin
                eq = 32'hFFFF_FFFF; er = a; ez = 1'b1;
            end else begin
                eq = a / b; er = a % b; ez = 1'b0;
            end
            drive_op(a, b, q, r, z, lat, bn, dw);
            vectors++; if (q !== eq) begin miscompares++; $display("FAIL rand%0d_q a=%0h b=%0h got=%0h exp=%0h", i, a, b, q, eq); end
            vectors++; if (r !== er) begin miscompares++; $display("FAIL rand%0d_r a=%0h b=%0h got=%0h exp=%0h", i, a, b, r, er); end
            vectors++; if (z !== ez) begin miscompares++; $display("FAIL rand%0d_dbz got=%b exp=%b", i, z, ez); end
            vectors++; if (lat != (ez ? 1 : 33)) begin miscompares++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, ez ? 1 : 33); end
            vectors++; if (dw != 1) begin miscompares++; $display("FAIL rand%0d_done_width got=%0d exp=1", i, dw); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        test_reset();
        test_basic();
        test_corners();
        test_div_zero();
        test_start_ignored();
        test_rst_mid_run();
        test_rst_with_start();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
